backtest_sequencer: RTL and testbench

Central controller for the daily backtest loop. It steps through the price ROM one day at a time and, for each day, runs four stages in order: price latch, per-stock return dividers, covariance sample, then the eigen/portfolio chain. After each day it strobes the capital-update logic. It replaces ad-hoc top-level sequencing with one FSM that has explicit handshakes, a watchdog and error reporting, and it sits between the price ROM and the qdiv/covariance/eigendecompose/eigenportfolio chain.

---
 rtl/backtest_sequencer_pkg.sv | 33 +++
 rtl/backtest_sequencer_if.sv | 36 +++
 rtl/backtest_sequencer_cycle_watchdog.sv | 37 +++
 rtl/backtest_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_backtest_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/backtest_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// backtest_pkg
// Shared types for the daily backtest sequencer: FSM state encoding, the
// error code reported on abort, and default sizing for the price vector.
// ---------------------------------------------------------------------------
package backtest_pkg;

    localparam int DEFAULT_N_STOCKS = 3;
    localparam int DEFAULT_WIDTH    = 16;

    // One day of prices, stock 0 in the least significant word.
    typedef logic [DEFAULT_N_STOCKS*DEFAULT_WIDTH-1:0] price_vec_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD     = 4'd1,
        DIV      = 4'd2,
        DIV_WAIT = 4'd3,
        COV      = 4'd4,
        PF_WAIT  = 4'd5,
        UPDATE   = 4'd6,
        DONE     = 4'd7,
        ERROR    = 4'd8
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OVF    = 2'd1,
        ERR_DIV_TO = 2'd2,
        ERR_PF_TO  = 2'd3
    } seq_err_e;

endpackage

// File: rtl/backtest_sequencer_if.sv
// ---------------------------------------------------------------------------
// backtest_sequencer_if
// Handshake bundle between the sequencer and the divider / covariance /
// portfolio chain.
//   div_start     sequencer -> dividers   one-cycle start pulse
//   div_complete  dividers  -> sequencer  per-divider completion
//   div_overflow  dividers  -> sequencer  per-divider overflow
//   cov_sample    sequencer -> covariance one-cycle sample pulse
//   pf_done       portfolio -> sequencer  portfolio chain finished
// master = sequencer side, slave = processing chain side.
// ---------------------------------------------------------------------------
interface backtest_sequencer_if #(
    parameter int N_STOCKS = backtest_pkg::DEFAULT_N_STOCKS
);
    logic                div_start;
    logic [N_STOCKS-1:0] div_complete;
    logic [N_STOCKS-1:0] div_overflow;
    logic                cov_sample;
    logic                pf_done;

    modport master (
        output div_start,
        output cov_sample,
        input  div_complete,
        input  div_overflow,
        input  pf_done
    );

    modport slave (
        input  div_start,
        input  cov_sample,
        output div_complete,
        output div_overflow,
        output pf_done
    );
endinterface

// File: rtl/backtest_sequencer_cycle_watchdog.sv
// ---------------------------------------------------------------------------
// cycle_watchdog
// Saturating wait-cycle counter used by the sequencer's wait states.
//   clk      system clock
//   rst      synchronous active-high reset
//   clear    zero the counter (takes priority over enable)
//   enable   count one cycle
//   expired  high while the count is >= TIMEOUT
// ---------------------------------------------------------------------------
module cycle_watchdog #(
    parameter int TIMEOUT = 4095,
    parameter int TO_W    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count;

    assign expired = (count >= TO_W'(TIMEOUT));

    // Stop counting once expired so the count can never wrap back below
    // the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/backtest_sequencer.sv
// ---------------------------------------------------------------------------
// backtest_sequencer
// Steps through the price ROM one day at a time and, for each day, runs
// price latch -> dividers -> covariance sample -> portfolio chain, then
// strobes the capital update.
//   clk, rst      clock, synchronous active-high reset
//   run           start request, sampled only in IDLE
//   day_addr      price ROM index
//   price_in      ROM data for day_addr (combinational)
//   old_prices    previous-day prices
//   new_prices    current-day prices
//   bus           handshake bundle (div_start/complete/overflow,
//                 cov_sample, pf_done)
//   update_en     one-cycle capital-update strobe
//   busy          high outside IDLE/DONE/ERROR
//   done, error   terminal status, held until reset
//   err_code      0 none, 1 overflow, 2 divider timeout, 3 portfolio timeout
//   days_done     number of update_en pulses issued
// ---------------------------------------------------------------------------
module backtest_sequencer
    import backtest_pkg::*;
#(
    parameter int N_STOCKS = DEFAULT_N_STOCKS,
    parameter int N_DAYS   = 76,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DAY_W    = 8,
    parameter int TIMEOUT  = 4095,
    parameter int TO_W     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    output logic [DAY_W-1:0]          day_addr,
    input  logic [N_STOCKS*WIDTH-1:0] price_in,
    output logic [N_STOCKS*WIDTH-1:0] old_prices,
    output logic [N_STOCKS*WIDTH-1:0] new_prices,
    backtest_sequencer_if.master      bus,
    output logic                      update_en,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [DAY_W-1:0]          days_done
);

    seq_state_e          state;
    seq_state_e          state_next;
    seq_err_e            err_q;
    seq_err_e            err_next;
    logic [N_STOCKS-1:0] mask;
    logic [N_STOCKS-1:0] mask_seen;
    logic                last_day;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    // Completions are sticky so single-cycle pulses from fast dividers are
    // not lost; this cycle's bits count toward the all-done decision.
    assign mask_seen = mask | bus.div_complete;
    assign last_day  = (day_addr == DAY_W'(N_DAYS - 1));
    assign err_code  = err_q;

    // The watchdog restarts on every state change and only runs while
    // waiting on an external responder.
    assign wd_clear  = (state_next != state);
    assign wd_enable = (state == DIV_WAIT) || (state == PF_WAIT);

    cycle_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Overflow is checked before completion so a divider reporting both in
    // the same cycle aborts the run. A timeout only matters if the wait
    // has not been satisfied in that same cycle.
    always_comb begin
        state_next = state;
        err_next   = err_q;
        unique case (state)
            IDLE:     if (run) state_next = LOAD;
            LOAD:     state_next = DIV;
            DIV:      state_next = DIV_WAIT;
            DIV_WAIT: begin
                if (|bus.div_overflow) begin
                    state_next = ERROR;
                    err_next   = ERR_OVF;
                end else if (&mask_seen) begin
                    state_next = COV;
                end else if (wd_expired) begin
                    state_next = ERROR;
                    err_next   = ERR_DIV_TO;
                end
            end
            COV:      state_next = PF_WAIT;
            PF_WAIT: begin
                if (bus.pf_done) begin
                    state_next = UPDATE;
                end else if (wd_expired) begin
                    state_next = ERROR;
                    err_next   = ERR_PF_TO;
                end
            end
            UPDATE:   state_next = last_day ? DONE : LOAD;
            DONE:     state_next = DONE;
            ERROR:    state_next = ERROR;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.div_start  = 1'b0;
        bus.cov_sample = 1'b0;
        update_en      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        unique case (state)
            IDLE:    ;
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: begin
                busy           = 1'b1;
                bus.div_start  = (state == DIV);
                bus.cov_sample = (state == COV);
                update_en      = (state == UPDATE);
            end
        endcase
    end

    // Day 0 is latched while leaving IDLE so the first LOAD can shift it
    // into old_prices while day 1 arrives from the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            day_addr   <= '0;
            old_prices <= '0;
            new_prices <= '0;
            mask       <= '0;
            err_q      <= ERR_NONE;
            days_done  <= '0;
        end else begin
            err_q <= err_next;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        new_prices <= price_in;
                        day_addr   <= DAY_W'(1);
                    end
                end
                LOAD: begin
                    old_prices <= new_prices;
                    new_prices <= price_in;
                    mask       <= '0;
                end
                DIV_WAIT: mask <= mask_seen;
                UPDATE: begin
                    days_done <= days_done + 1'b1;
                    if (!last_day) begin
                        day_addr <= day_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_backtest_sequencer.sv
// ---------------------------------------------------------------------------
// tb_backtest_sequencer
// Bench for backtest_sequencer with a 4-day ROM and a 16-cycle watchdog.
// A responder process models the dividers and portfolio chain; a monitor
// pops per-day expectations from scoreboard queues as strobes appear.
// ---------------------------------------------------------------------------
module tb_backtest_sequencer;

    localparam int N_STOCKS = 3;
    localparam int N_DAYS   = 4;
    localparam int WIDTH    = 16;
    localparam int DAY_W    = 8;
    localparam int TIMEOUT  = 16;
    localparam int TO_W     = 12;
    localparam int PW       = N_STOCKS * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [DAY_W-1:0] day_addr;
    logic [DAY_W-1:0] days_done;
    logic [PW-1:0] price_in;
    logic [PW-1:0] old_prices;
    logic [PW-1:0] new_prices;
    logic          update_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    backtest_sequencer_if #(.N_STOCKS(N_STOCKS)) bus ();

    backtest_sequencer #(
        .N_STOCKS (N_STOCKS),
        .N_DAYS   (N_DAYS),
        .WIDTH    (WIDTH),
        .DAY_W    (DAY_W),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .day_addr   (day_addr),
        .price_in   (price_in),
        .old_prices (old_prices),
        .new_prices (new_prices),
        .bus        (bus),
        .update_en  (update_en),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .days_done  (days_done)
    );

    always #5 clk = ~clk;

    // Price ROM model, stock 0 in the low word.
    function automatic logic [PW-1:0] rom_word(input int day);
        logic [WIDTH-1:0] p0, p1, p2;
        case (day)
            0:       begin p0 = 16'd10106; p1 = 16'd13386; p2 = 16'd25886; end
            1:       begin p0 = 16'd9100;  p1 = 16'd13005; p2 = 16'd24934; end
            2:       begin p0 = 16'd9350;  p1 = 16'd13120; p2 = 16'd25010; end
            3:       begin p0 = 16'd9800;  p1 = 16'd12877; p2 = 16'd25502; end
            default: begin p0 = 16'hBAD0; p1 = 16'hBAD1;   p2 = 16'hBAD2;   end
        endcase
        return {p2, p1, p0};
    endfunction

    assign price_in = rom_word(int'(day_addr));

    typedef struct {
        string    name;
        int       d0, d1, d2;
        int       pf;
        int       ovf_day;
        logic     exp_error;
        logic [1:0] exp_code;
        int       exp_days_done;
        int       exp_day_addr;
        int       exp_covs;
    } scen_t;

    typedef struct {
        logic [PW-1:0] old_p;
        logic [PW-1:0] new_p;
    } price_exp_t;

    typedef struct {
        int day;
        int done_before;
    } upd_exp_t;

    price_exp_t div_q[$];
    upd_exp_t   upd_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Responder configuration and outputs.
    int   dly[3];
    int   pf_dly;
    int   ovf_day;
    logic [2:0] resp_cmp;
    logic [2:0] resp_ovf;
    logic resp_pf;
    logic manual_pf;

    assign bus.div_complete = resp_cmp;
    assign bus.div_overflow = resp_ovf;
    assign bus.pf_done      = resp_pf | manual_pf;

    // Monitor state.
    int cyc = 0;
    int last_div_cyc, last_cov_cyc, last_upd_cyc, err_cyc;
    int n_upd, n_cov;
    int exp_cov_lat, exp_period;
    bit cov_this_day;
    logic error_q = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Responder: request seen in cycle c gives a response in cycle c+d.
    initial begin
        int cnt[3];
        int pf_cnt, ovf_cnt;
        resp_cmp = '0; resp_ovf = '0; resp_pf = 1'b0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        pf_cnt = 0; ovf_cnt = 0;
        forever begin
            @(posedge clk); #1;
            resp_cmp = '0; resp_ovf = '0; resp_pf = 1'b0;
            if (rst) begin
                for (int i = 0; i < 3; i++) cnt[i] = 0;
                pf_cnt = 0; ovf_cnt = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) resp_cmp[i] = 1'b1;
                    end
                end
                if (pf_cnt > 0) begin
                    pf_cnt--;
                    if (pf_cnt == 0) resp_pf = 1'b1;
                end
                if (ovf_cnt > 0) begin
                    ovf_cnt--;
                    if (ovf_cnt == 0) begin
                        resp_ovf = 3'b010;
                        resp_cmp = 3'b111;
                    end
                end
                if (bus.div_start) begin
                    if (ovf_day != 0 && int'(day_addr) == ovf_day) ovf_cnt = 1;
                    else for (int i = 0; i < 3; i++) cnt[i] = dly[i];
                end
                if (bus.cov_sample) pf_cnt = pf_dly;
            end
        end
    end

    // Monitor: scoreboard pops and per-strobe timing checks.
    always @(negedge clk) begin
        price_exp_t pe;
        upd_exp_t   ue;
        cyc++;
        if (bus.div_start || bus.cov_sample || update_en) begin
            checkOutput("strobe_onehot",
                        64'(int'(bus.div_start) + int'(bus.cov_sample) + int'(update_en)), 64'd1);
        end
        if (bus.div_start) begin
            last_div_cyc = cyc;
            cov_this_day = 1'b0;
            checkOutput("div_expected", 64'(div_q.size() != 0), 64'd1);
            if (div_q.size() != 0) begin
                pe = div_q.pop_front();
                checkOutput("old_prices_at_div", 64'(old_prices), 64'(pe.old_p));
                checkOutput("new_prices_at_div", 64'(new_prices), 64'(pe.new_p));
            end
        end
        if (bus.cov_sample) begin
            n_cov++;
            checkOutput("cov_once_per_day", 64'(cov_this_day), 64'd0);
            cov_this_day = 1'b1;
            if (exp_cov_lat > 0) checkOutput("cov_latency", 64'(cyc - last_div_cyc), 64'(exp_cov_lat));
            last_cov_cyc = cyc;
        end
        if (update_en) begin
            n_upd++;
            checkOutput("day_addr_bound", 64'(day_addr <= DAY_W'(N_DAYS - 1)), 64'd1);
            checkOutput("update_expected", 64'(upd_q.size() != 0), 64'd1);
            if (upd_q.size() != 0) begin
                ue = upd_q.pop_front();
                checkOutput("update_day_addr", 64'(day_addr), 64'(ue.day));
                checkOutput("update_days_done", 64'(days_done), 64'(ue.done_before));
            end
            if (exp_period > 0 && last_upd_cyc >= 0)
                checkOutput("day_period", 64'(cyc - last_upd_cyc), 64'(exp_period));
            last_upd_cyc = cyc;
        end
        if (error && !error_q) err_cyc = cyc;
        error_q = error;
    end

    task automatic clearMonitor();
        div_q.delete();
        upd_q.delete();
        n_upd = 0; n_cov = 0;
        last_div_cyc = -1; last_cov_cyc = -1; last_upd_cyc = -1; err_cyc = -1;
        exp_cov_lat = 0; exp_period = 0;
        cov_this_day = 1'b0;
    endtask

    task automatic configure(input scen_t s);
        dly[0] = s.d0; dly[1] = s.d1; dly[2] = s.d2;
        pf_dly = s.pf; ovf_day = s.ovf_day;
    endtask

    task automatic pushExpect(input scen_t s);
        price_exp_t pe;
        upd_exp_t   ue;
        int         m;
        for (int k = 1; k <= s.exp_day_addr; k++) begin
            pe.old_p = rom_word(k - 1);
            pe.new_p = rom_word(k);
            div_q.push_back(pe);
        end
        for (int k = 1; k <= s.exp_days_done; k++) begin
            ue.day = k;
            ue.done_before = k - 1;
            upd_q.push_back(ue);
        end
        m = max3(s.d0, s.d1, s.d2);
        exp_cov_lat = (s.d0 > 0 && s.d1 > 0 && s.d2 > 0) ? m + 1 : 0;
        exp_period  = (exp_cov_lat > 0 && s.pf > 0) ? 4 + m + s.pf : 0;
    endtask

    task automatic startRun();
        @(posedge clk); #2;
        run = 1'b1;
        @(posedge clk); #2;
        run = 1'b0;
    endtask

    task automatic applyStimulus(input scen_t s);
        rst = 1'b1; run = 1'b0; manual_pf = 1'b0;
        configure(s);
        repeat (2) @(posedge clk);
        #2;
        clearMonitor();
        pushExpect(s);
        rst = 1'b0;
        startRun();
    endtask

    task automatic waitEnd(input string name);
        for (int t = 0; t < 2000 && !(done || error); t++) begin
            @(posedge clk); #2;
        end
        checkOutput({name, "_finished_in_budget"}, 64'(done || error), 64'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic checkScenario(input scen_t s);
        int dwell;
        checkOutput({s.name, "_done"}, 64'(done), 64'(!s.exp_error));
        checkOutput({s.name, "_error"}, 64'(error), 64'(s.exp_error));
        checkOutput({s.name, "_err_code"}, 64'(err_code), 64'(s.exp_code));
        checkOutput({s.name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({s.name, "_days_done"}, 64'(days_done), 64'(s.exp_days_done));
        checkOutput({s.name, "_day_addr"}, 64'(day_addr), 64'(s.exp_day_addr));
        checkOutput({s.name, "_old_prices"}, 64'(old_prices), 64'(rom_word(s.exp_day_addr - 1)));
        checkOutput({s.name, "_new_prices"}, 64'(new_prices), 64'(rom_word(s.exp_day_addr)));
        checkOutput({s.name, "_update_pulses"}, 64'(n_upd), 64'(s.exp_days_done));
        checkOutput({s.name, "_cov_pulses"}, 64'(n_cov), 64'(s.exp_covs));
        checkOutput({s.name, "_div_queue_drained"}, 64'(div_q.size()), 64'd0);
        checkOutput({s.name, "_upd_queue_drained"}, 64'(upd_q.size()), 64'd0);
        if (s.exp_code == 2'd2 || s.exp_code == 2'd3) begin
            dwell = err_cyc - ((s.exp_code == 2'd2) ? last_div_cyc : last_cov_cyc) - 1;
            checkOutput({s.name, "_timeout_dwell"},
                        64'(dwell >= TIMEOUT && dwell <= TIMEOUT + 1), 64'd1);
        end
    endtask

    initial begin
        scen_t scen[6];
        scen_t rs;
        bit    found;

        //             name          d0 d1 d2 pf  ovf  err   code  dd addr covs
        scen[0] = '{"normal",        5, 5, 5, 10, 0, 1'b0, 2'd0, 3, 3, 3};
        scen[1] = '{"ideal",         1, 1, 1, 1,  0, 1'b0, 2'd0, 3, 3, 3};
        scen[2] = '{"staggered",     2, 7, 4, 3,  0, 1'b0, 2'd0, 3, 3, 3};
        scen[3] = '{"overflow",      1, 1, 1, 2,  2, 1'b1, 2'd1, 1, 2, 1};
        scen[4] = '{"div_timeout",   1, 0, 1, 1,  0, 1'b1, 2'd2, 0, 1, 0};
        scen[5] = '{"pf_timeout",    1, 1, 1, 0,  0, 1'b1, 2'd3, 0, 1, 1};

        rst = 1'b1; run = 1'b0; manual_pf = 1'b0;
        configure(scen[1]);
        clearMonitor();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_day_addr", 64'(day_addr), 64'd0);
        checkOutput("reset_prices", 64'(old_prices | new_prices), 64'd0);
        checkOutput("reset_status", 64'({busy, done, error, update_en, bus.div_start, bus.cov_sample}), 64'd0);
        checkOutput("reset_err_code", 64'(err_code), 64'd0);
        checkOutput("reset_days_done", 64'(days_done), 64'd0);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] scenario %s", scen[i].name);
            applyStimulus(scen[i]);
            waitEnd(scen[i].name);
            checkScenario(scen[i]);
        end

        // Still in ERROR from the portfolio timeout: late pf_done and run
        // must not move anything.
        manual_pf = 1'b1; run = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        manual_pf = 1'b0; run = 1'b0;
        checkOutput("sticky_error", 64'(error), 64'd1);
        checkOutput("sticky_not_done", 64'(done), 64'd0);
        checkOutput("sticky_err_code", 64'(err_code), 64'd3);
        checkOutput("sticky_day_addr", 64'(day_addr), 64'd1);
        checkOutput("sticky_no_update", 64'(n_upd), 64'd0);

        // Reset while waiting on the portfolio for day 2.
        $display("[TB] scenario reset_mid_run");
        rs = '{"reset_mid_run", 1, 1, 1, 10, 0, 1'b0, 2'd0, 1, 2, 2};
        rst = 1'b1;
        configure(rs);
        repeat (2) @(posedge clk);
        #2;
        clearMonitor();
        pushExpect(rs);
        rst = 1'b0;
        startRun();
        found = 1'b0;
        for (int t = 0; t < 500 && !found; t++) begin
            @(posedge clk); #2;
            if (bus.cov_sample && day_addr == DAY_W'(2)) found = 1'b1;
        end
        checkOutput("reached_day2_cov", 64'(found), 64'd1);
        @(posedge clk); #2;
        checkOutput("in_pf_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("midreset_day_addr", 64'(day_addr), 64'd0);
        checkOutput("midreset_prices", 64'(old_prices | new_prices), 64'd0);
        checkOutput("midreset_status", 64'({busy, done, error, update_en, bus.div_start, bus.cov_sample}), 64'd0);
        checkOutput("midreset_counts", 64'({err_code, days_done}), 64'd0);
        checkOutput("midreset_updates", 64'(n_upd), 64'd1);
        checkOutput("midreset_div_queue", 64'(div_q.size()), 64'd0);

        // Fresh run straight out of that reset.
        rs = scen[1];
        rs.name = "rerun";
        configure(rs);
        clearMonitor();
        pushExpect(rs);
        rst = 1'b0;
        startRun();
        waitEnd(rs.name);
        checkScenario(rs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] global timeout");
    end

endmodule
